// File: rtl/toll_pkg.sv
// rtl/toll_pkg.sv - shared toll-lane types, axle-code constants and weight width
//   Used by vehicle_sensor_frontend and the downstream classifier.
package toll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASSING,
    REPORT,
    FAULT
  } state_e;

  localparam int unsigned AXLE_CODE_MIN = 0;
  localparam int unsigned AXLE_CODE_MAX = 3;
  localparam int unsigned AXLE_BASE     = 2;
  localparam int unsigned WEIGHT_W      = 4;

  // Axle count -> 2-bit code: axles-2, clamped to AXLE_CODE_MIN..AXLE_CODE_MAX.
  function automatic logic [1:0] axle_code(input int unsigned axles);
    if (axles < AXLE_BASE) begin
      return 2'(AXLE_CODE_MIN);
    end else if ((axles - AXLE_BASE) > AXLE_CODE_MAX) begin
      return 2'(AXLE_CODE_MAX);
    end else begin
      return 2'(axles - AXLE_BASE);
    end
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - 2-FF synchronizer, stability debouncer, edge pulses
//   clk, rst : clock, async active-high reset
//   raw_n    : raw active-low sensor, asynchronous to clk
//   level    : debounced active-high level (0 = inactive after reset)
//   rise     : one-cycle pulse when level goes inactive -> active
//   fall     : one-cycle pulse when level goes active -> inactive
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active;

  // Synchronizer resets to the idle (high) raw level so no false edge appears.
  assign active = ~sync2_q;

  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (active == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
      level_d = active;
      cnt_d   = '0;
      rise_d  = active;
      fall_d  = ~active;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/vehicle_sensor_frontend.sv
// rtl/vehicle_sensor_frontend.sv - per-vehicle axle count / peak weight record builder
//   clk, rst       : clock, async active-high reset
//   presence_n     : raw loop detector (active-low, async)
//   axle_n         : raw axle tread sensor (active-low, async)
//   weight_in      : scale reading
//   eixos, peso    : axle code and peak weight of the last vehicle
//   vehicle_valid  : one-cycle strobe with a new record
//   axle_err       : last vehicle had fewer than 2 axles
//   timeout_err    : presence stuck, sticky until presence falls
//   busy           : PASSING or FAULT
//   vehicle_count  : wrapping record counter, only with VEHICLE_COUNT_EN defined
module vehicle_sensor_frontend
  import toll_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000,
  parameter int unsigned AXLE_CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                presence_n,
  input  logic                axle_n,
  input  logic [WEIGHT_W-1:0] weight_in,
  output logic [1:0]          eixos,
  output logic [WEIGHT_W-1:0] peso,
  output logic                vehicle_valid,
  output logic                axle_err,
  output logic                timeout_err,
  output logic                busy
`ifdef VEHICLE_COUNT_EN
  ,
  output logic [15:0]         vehicle_count
`endif
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AXLE_CNT_W-1:0] AXLE_SAT = '1;

  logic pres_level, pres_rise_unused, pres_fall;
  logic axle_level_unused, axle_rise, axle_fall_unused;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pres_db (
    .clk   (clk),
    .rst   (rst),
    .raw_n (presence_n),
    .level (pres_level),
    .rise  (pres_rise_unused),
    .fall  (pres_fall)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_axle_db (
    .clk   (clk),
    .rst   (rst),
    .raw_n (axle_n),
    .level (axle_level_unused),
    .rise  (axle_rise),
    .fall  (axle_fall_unused)
  );

  state_e                state_q, state_d;
  logic [AXLE_CNT_W-1:0] axle_cnt_q, axle_cnt_d;
  logic [WEIGHT_W-1:0]   peak_q, peak_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [1:0]            eixos_q, eixos_d;
  logic [WEIGHT_W-1:0]   peso_q, peso_d;
  logic                  axle_err_q, axle_err_d;
  logic                  valid_q, valid_d;
  logic                  tmo_err_q, tmo_err_d;

  // Values including this cycle's axle event and weight sample, so an axle
  // debouncing together with presence fall still lands in the record.
  logic [AXLE_CNT_W-1:0] axles_now;
  logic [WEIGHT_W-1:0]   peak_now;

  always_comb begin
    axles_now = axle_cnt_q;
    if (axle_rise && (axle_cnt_q != AXLE_SAT)) begin
      axles_now = axle_cnt_q + 1'b1;
    end
    peak_now = (weight_in > peak_q) ? weight_in : peak_q;
  end

  always_comb begin
    state_d    = state_q;
    axle_cnt_d = axle_cnt_q;
    peak_d     = peak_q;
    tmo_d      = tmo_q;
    eixos_d    = eixos_q;
    peso_d     = peso_q;
    axle_err_d = axle_err_q;
    valid_d    = 1'b0;
    tmo_err_d  = tmo_err_q;
    case (state_q)
      IDLE: begin
        // Level, not the rise pulse: a rise landing on the REPORT cycle (or a
        // presence still active after reset) starts a passage from here.
        if (pres_level) begin
          state_d    = PASSING;
          axle_cnt_d = '0;
          peak_d     = '0;
          tmo_d      = '0;
        end
      end
      PASSING: begin
        axle_cnt_d = axles_now;
        peak_d     = peak_now;
        tmo_d      = tmo_q + 1'b1;
        if (pres_fall) begin
          // Record registers load on entry so they are visible in REPORT.
          state_d    = REPORT;
          eixos_d    = axle_code(32'(axles_now));
          peso_d     = peak_now;
          axle_err_d = (32'(axles_now) < AXLE_BASE);
          valid_d    = 1'b1;
        end else if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
          state_d   = FAULT;
          tmo_err_d = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (pres_fall) begin
          state_d   = IDLE;
          tmo_err_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      axle_cnt_q <= '0;
      peak_q     <= '0;
      tmo_q      <= '0;
      eixos_q    <= '0;
      peso_q     <= '0;
      axle_err_q <= 1'b0;
      valid_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      axle_cnt_q <= axle_cnt_d;
      peak_q     <= peak_d;
      tmo_q      <= tmo_d;
      eixos_q    <= eixos_d;
      peso_q     <= peso_d;
      axle_err_q <= axle_err_d;
      valid_q    <= valid_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign eixos         = eixos_q;
  assign peso          = peso_q;
  assign axle_err      = axle_err_q;
  assign vehicle_valid = valid_q;
  assign timeout_err   = tmo_err_q;
  assign busy          = (state_q == PASSING) || (state_q == FAULT);

`ifdef VEHICLE_COUNT_EN
  logic [15:0] vcount_q, vcount_d;

  always_comb begin
    vcount_d = vcount_q;
    if (valid_q) begin
      vcount_d = vcount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount_q <= '0;
    end else begin
      vcount_q <= vcount_d;
    end
  end

  assign vehicle_count = vcount_q;
`endif

endmodule
